ahb_mem_slave: RTL

//   AHB-Lite slave (responder) with a local word-addressed memory, driven by one hsel_N from the

---
 rtl/ahb_mem_slave.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: word-organised local RAM with byte/half/word writes,
// programmable OKAY wait states and two-cycle ERROR responses.
module ahb_mem_slave #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [15:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t state, state_nxt;

    logic [13:0]   addr_p1;
    logic          write_p1;
    logic [2:0]    size_p1;
    logic          err_p1;
    logic [3:0]    wait_cnt;
    logic [31:0]   rdata_p1;
    logic [31:0]   mem [DEPTH];

    logic          can_accept;
    logic          accept;
    logic          err_in;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [31:0]   wr_word;
    logic [AW-1:0] rd_idx;
    logic          rd_load;
    logic [31:0]   rd_word;
    logic          unused_ok;

    function automatic logic addr_error(input logic [13:0] a, input logic [2:0] sz);
        logic [31:0] idx;
        idx = {20'd0, a[13:2]};
        addr_error = (sz > 3'd2)
                  || (sz == 3'd1 && a[0])
                  || (sz == 3'd2 && a[1:0] != 2'b00)
                  || (idx >= 32'(DEPTH));
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] a, input logic [2:0] sz);
        case (sz)
            3'd0:    lane_mask = 4'b0001 << a;
            3'd1:    lane_mask = a[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        merge_lanes = old_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) merge_lanes[8*i +: 8] = new_word[8*i +: 8];
        end
    endfunction

    // Address phase decode: only sample while our own data phase is completing.
    assign can_accept = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
    assign accept     = can_accept && hsel && hready && htrans[1];
    assign err_in     = addr_error(haddr[13:0], hsize);

    // Write commit happens on the edge that closes an OKAY write data phase.
    assign wr_en   = (state == ST_DATA) && write_p1 && !err_p1 && hresetn;
    assign wr_idx  = addr_p1[AW+1:2];
    assign wr_word = merge_lanes(mem[wr_idx], hwdata, lane_mask(addr_p1[1:0], size_p1));

    // Read data is captured on the edge entering DATA; a write committing on that
    // same edge to the same word is forwarded so the read sees the new contents.
    assign rd_idx  = (state == ST_WAIT) ? addr_p1[AW+1:2] : haddr[AW+1:2];
    assign rd_load = (state_nxt == ST_DATA) && !((state == ST_WAIT) ? write_p1 : hwrite);
    assign rd_word = (wr_en && wr_idx == rd_idx) ? wr_word : mem[rd_idx];

    assign unused_ok = &{1'b0, haddr[15:14], htrans[0]};

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (!accept)
                    state_nxt = ST_IDLE;
                else if (err_in)
                    state_nxt = ST_ERR1;
                else if (WAIT_STATES > 0)
                    state_nxt = ST_WAIT;
                else
                    state_nxt = ST_DATA;
            end
            ST_WAIT: begin
                if (wait_cnt == 4'(WAIT_STATES - 1)) state_nxt = ST_DATA;
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        case (state)
            ST_WAIT: hreadyout = 1'b0;
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
            end
            ST_ERR2: hresp = 1'b1;
            default: ;
        endcase
    end

    assign hrdata = rdata_p1;

    // Control and pending-transfer registers.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state    <= ST_IDLE;
            addr_p1  <= '0;
            write_p1 <= 1'b0;
            size_p1  <= '0;
            err_p1   <= 1'b0;
            wait_cnt <= '0;
            rdata_p1 <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 4'd1 : 4'd0;
            if (accept) begin
                addr_p1  <= haddr[13:0];
                write_p1 <= hwrite;
                size_p1  <= hsize;
                err_p1   <= err_in;
            end
            if (rd_load) rdata_p1 <= rd_word;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge hclk) begin
        if (wr_en) mem[wr_idx] <= wr_word;
    end

endmodule
